// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs for ALU and LSU, one
// round-robin grant per cycle onto a registered CDB, flushed on rollback.
module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ROB_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              rollback_flag_in,
    input  logic              alu_valid_in,
    input  logic [ROB_W-1:0]  alu_rob_id_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              alu_jump_flag_in,
    input  logic [DATA_W-1:0] alu_target_pos_in,
    output logic              alu_ready_out,
    input  logic              lsu_valid_in,
    input  logic [ROB_W-1:0]  lsu_rob_id_in,
    input  logic [DATA_W-1:0] lsu_result_in,
    output logic              lsu_ready_out,
    output logic              cdb_valid_out,
    output logic              cdb_src_out,
    output logic [ROB_W-1:0]  cdb_rob_id_out,
    output logic [DATA_W-1:0] cdb_result_out,
    output logic              cdb_jump_flag_out,
    output logic [DATA_W-1:0] cdb_target_pos_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ROB_W-1:0]  alu_rob_mem [DEPTH];
    logic [DATA_W-1:0] alu_res_mem [DEPTH];
    logic              alu_jump_mem[DEPTH];
    logic [DATA_W-1:0] alu_tgt_mem [DEPTH];
    logic [ROB_W-1:0]  lsu_rob_mem [DEPTH];
    logic [DATA_W-1:0] lsu_res_mem [DEPTH];

    logic [PTR_W-1:0] alu_rptr_reg, alu_wptr_reg, lsu_rptr_reg, lsu_wptr_reg;
    logic [CNT_W-1:0] alu_cnt_reg, lsu_cnt_reg, alu_cnt_next, lsu_cnt_next;
    logic             last_grant_reg;

    logic alu_push, lsu_push, grant_alu, grant_lsu, alu_nonempty, lsu_nonempty, active;

    assign alu_ready_out = rdy_in && (alu_cnt_reg < CNT_W'(DEPTH));
    assign lsu_ready_out = rdy_in && (lsu_cnt_reg < CNT_W'(DEPTH));

    // Cycles that may change queue state: out of reset, enabled, not flushing.
    assign active       = rst_n_in && rdy_in && !rollback_flag_in;
    assign alu_nonempty = (alu_cnt_reg != '0);
    assign lsu_nonempty = (lsu_cnt_reg != '0);

    assign alu_push = active && alu_valid_in && alu_ready_out && (alu_rob_id_in != '0);
    assign lsu_push = active && lsu_valid_in && lsu_ready_out && (lsu_rob_id_in != '0);

    // Round-robin: on contention the source that did not win last time goes.
    assign grant_alu = active && alu_nonempty && (!lsu_nonempty || last_grant_reg);
    assign grant_lsu = active && lsu_nonempty && (!alu_nonempty || !last_grant_reg);

    always_comb begin
        alu_cnt_next = alu_cnt_reg;
        lsu_cnt_next = lsu_cnt_reg;
        if (alu_push && !grant_alu) alu_cnt_next = alu_cnt_reg + CNT_W'(1);
        if (!alu_push && grant_alu) alu_cnt_next = alu_cnt_reg - CNT_W'(1);
        if (lsu_push && !grant_lsu) lsu_cnt_next = lsu_cnt_reg + CNT_W'(1);
        if (!lsu_push && grant_lsu) lsu_cnt_next = lsu_cnt_reg - CNT_W'(1);
    end

    // Queue storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_rob_mem[alu_wptr_reg]  <= alu_rob_id_in;
            alu_res_mem[alu_wptr_reg]  <= alu_result_in;
            alu_jump_mem[alu_wptr_reg] <= alu_jump_flag_in;
            alu_tgt_mem[alu_wptr_reg]  <= alu_target_pos_in;
        end
        if (lsu_push) begin
            lsu_rob_mem[lsu_wptr_reg] <= lsu_rob_id_in;
            lsu_res_mem[lsu_wptr_reg] <= lsu_result_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            alu_rptr_reg       <= '0;
            alu_wptr_reg       <= '0;
            alu_cnt_reg        <= '0;
            lsu_rptr_reg       <= '0;
            lsu_wptr_reg       <= '0;
            lsu_cnt_reg        <= '0;
            last_grant_reg     <= 1'b1;
            cdb_valid_out      <= 1'b0;
            cdb_src_out        <= 1'b0;
            cdb_rob_id_out     <= '0;
            cdb_result_out     <= '0;
            cdb_jump_flag_out  <= 1'b0;
            cdb_target_pos_out <= '0;
        end else if (rdy_in) begin
            if (rollback_flag_in) begin
                alu_rptr_reg   <= '0;
                alu_wptr_reg   <= '0;
                alu_cnt_reg    <= '0;
                lsu_rptr_reg   <= '0;
                lsu_wptr_reg   <= '0;
                lsu_cnt_reg    <= '0;
                last_grant_reg <= 1'b1;
                cdb_valid_out  <= 1'b0;
            end else begin
                if (alu_push)  alu_wptr_reg <= alu_wptr_reg + PTR_W'(1);
                if (grant_alu) alu_rptr_reg <= alu_rptr_reg + PTR_W'(1);
                if (lsu_push)  lsu_wptr_reg <= lsu_wptr_reg + PTR_W'(1);
                if (grant_lsu) lsu_rptr_reg <= lsu_rptr_reg + PTR_W'(1);
                alu_cnt_reg   <= alu_cnt_next;
                lsu_cnt_reg   <= lsu_cnt_next;
                cdb_valid_out <= grant_alu || grant_lsu;
                if (grant_alu) begin
                    last_grant_reg     <= 1'b0;
                    cdb_src_out        <= 1'b0;
                    cdb_rob_id_out     <= alu_rob_mem[alu_rptr_reg];
                    cdb_result_out     <= alu_res_mem[alu_rptr_reg];
                    cdb_jump_flag_out  <= alu_jump_mem[alu_rptr_reg];
                    cdb_target_pos_out <= alu_tgt_mem[alu_rptr_reg];
                end else if (grant_lsu) begin
                    last_grant_reg     <= 1'b1;
                    cdb_src_out        <= 1'b1;
                    cdb_rob_id_out     <= lsu_rob_mem[lsu_rptr_reg];
                    cdb_result_out     <= lsu_res_mem[lsu_rptr_reg];
                    cdb_jump_flag_out  <= 1'b0;
                    cdb_target_pos_out <= '0;
                end
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the ALU and LSU result producers and the reorder buffer, reservation stations and load/store buffer. Each producer gets a small result queue. Every cycle one queued result is granted round-robin and broadcast on a single registered CDB. All queued results are discarded on rollback.

## Interface
Parameters:
- DEPTH, 2: entries per source queue; power of two, ≥2.
- ROB_W, 5: ROB id width; id 0 means "none", valid ids are 1..31.
- DATA_W, 32: result, target and data width.

Ports:
- clk_in  in  1  single clock, rising edge.
- rst_n_in  in  1  synchronous active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- rollback_flag_in  in  1  flush request from ROB.
- alu_valid_in  in  1  ALU result present.
- alu_rob_id_in  in  ROB_W  destination ROB id.
- alu_result_in  in  DATA_W  ALU result.
- alu_jump_flag_in  in  1  branch taken.
- alu_target_pos_in  in  DATA_W  branch target.
- alu_ready_out  out  1  ALU queue can accept.
- lsu_valid_in  in  1  LSU result present.
- lsu_rob_id_in  in  ROB_W  destination ROB id.
- lsu_result_in  in  DATA_W  load data.
- lsu_ready_out  out  1  LSU queue can accept.
- cdb_valid_out  out  1  broadcast valid.
- cdb_src_out  out  1  0 = ALU, 1 = LSU.
- cdb_rob_id_out  out  ROB_W  broadcast ROB id.
- cdb_result_out  out  DATA_W  broadcast data.
- cdb_jump_flag_out  out  1  jump flag; 0 for LSU entries.
- cdb_target_pos_out  out  DATA_W  target; 0 for LSU entries.

## Operation
Queues:
- Each source has a FIFO with its own read pointer, write pointer and count.
- Pointers wrap modulo DEPTH; the count is clog2(DEPTH)+1 bits wide.
- ALU entries hold {rob_id, result, jump_flag, target}. LSU entries hold {rob_id, result}.
- `*_ready_out` = rdy_in && (count < DEPTH). This is combinational from registered count only; a same-cycle pop does not raise ready.
- Enqueue at an edge requires rst_n_in=1, rdy_in=1, rollback_flag_in=0, valid=1, ready=1 and rob_id≠0.
- A valid input with rob_id=0 is dropped silently.

Arbitration:
- The `last_grant` register resets to 1 (LSU), so the ALU wins the first tie.
- When both queues are non-empty, the source not equal to `last_grant` is granted.
- When only one queue is non-empty, that queue is granted.
- A grant pops the head entry, registers it onto the CDB, and sets `last_grant` to the granted source.

CDB outputs:
- No grant: cdb_valid_out←0; the data outputs hold their previous values.
- LSU grant: jump_flag←0 and target_pos←0.

Rollback (rollback_flag_in=1 at an edge with rdy_in=1):
- Both counts and pointers clear to 0.
- cdb_valid_out←0 and last_grant←1.
- Inputs at that edge are dropped.
- Rollback takes priority over enqueue and grant.

rdy_in=0:
- All registers hold, including cdb_valid_out.
- Ready outputs are 0.

Reset (rst_n_in=0 at an edge, regardless of rdy_in):
- cdb_valid_out, cdb_src_out, cdb_rob_id_out, cdb_result_out, cdb_jump_flag_out and cdb_target_pos_out are all 0.
- Counts and pointers are 0; last_grant is 1.
- Ready outputs read 1 once rst_n_in=1 and rdy_in=1.
- Reset in the middle of traffic discards all queued entries.

## Timing
- Latency: an input accepted at edge k into an empty queue, with no competing queue, is on the CDB after edge k+1, valid for exactly one cycle.
- Throughput: one broadcast per cycle total. Under contention each source gets at least 1 grant per 2 cycles.
- Bypass: none; queue input never drives the CDB in the same cycle.
- Simultaneous enqueue and pop on one queue: count is unchanged and both happen.
- Ordering: per-source FIFO order is preserved, and no entry is lost or duplicated except on rollback or reset.
- Ready: combinational from rdy_in and registered count, with no path from valid to ready.

## Test plan
- **Reset:** rst_n_in=0 for 2 cycles, then 1 with rdy_in=1 → all CDB outputs 0, alu_ready_out=lsu_ready_out=1.
- **Single ALU result:** alu_valid_in with id=3, result=0x11, jump=1, target=0x100 at edge k → after edge k+1: cdb_valid=1, src=0, id=3, result=0x11, jump=1, target=0x100; after edge k+2: cdb_valid=0.
- **Tie and round-robin:** ALU ids 1,2 and LSU ids 5,6 presented together on two consecutive edges → CDB ids 1,5,2,6 on four consecutive cycles, src 0,1,0,1. LSU entries show jump=0 and target=0.
- **Saturation, DEPTH=2:** both sources valid every cycle for 10 cycles with incrementing ids → each ready deasserts while its count=2, every accepted id is broadcast exactly once in per-source order, and sources alternate.
- **Rollback:** 2 ALU and 1 LSU entries pending, then pulse rollback_flag_in with a new ALU id=9 presented → next cycle cdb_valid=0, both ready=1, pending ids never broadcast, id 9 dropped. ALU id=4 sent afterwards appears after 1 cycle.
- **Edge inputs:** LSU valid with id=0 → never broadcast. rdy_in=0 for 3 cycles with a pending entry → CDB outputs and queues frozen and ready=0; broadcast resumes 1 cycle after rdy_in=1.
